// File: rtl/hazard_ctrl_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   - forward select encodings (FWD_RF / FWD_WB / FWD_MEM)
//   - multi-cycle sequencer state type (IDLE / BUSY)
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

  // True when a writing stage targets a non-zero register matching the source.
  function automatic logic reg_hit(input logic we, input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: D/E/M/W control taps into the hazard controller and the
// stall/flush/forward/sequencing controls back to the stage registers.
//   master : pipeline side (drives register indices and control bits)
//   slave  : hazard controller side (drives forward/stall/flush/mc/counters)
// Parameter CNT_W sets the performance counter width.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  import hazard_pkg::*;

  logic [REG_W-1:0] Rs1D, Rs2D;
  logic [REG_W-1:0] Rs1E, Rs2E, RdE;
  logic             ResultSrcE;
  logic             MultiCycleE;
  logic             PCSrcE;
  logic [REG_W-1:0] RdM, RdW;
  logic             RegWriteM, RegWriteW;

  logic [FWD_W-1:0] ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE;
  logic             FlushD, FlushE, FlushM;
  logic             McStartE, McDoneE;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, MultiCycleE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           FlushM, McStartE, McDoneE, StallCnt, FlushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, MultiCycleE, PCSrcE,
           RdM, RdW, RegWriteM, RegWriteW,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE,
           FlushM, McStartE, McDoneE, StallCnt, FlushCnt
  );

endinterface

// File: rtl/hazard_ctrl_fwd.sv
// fwd_sel: per-operand execute-stage forwarding select.
//   en_i          : output forced to FWD_RF when low (reset)
//   rs_e_i        : source register of the instruction in E
//   rd_m_i/rd_w_i : destinations in M and W
//   reg_write_*_i : M / W write enables
//   fwd_o         : FWD_MEM / FWD_WB / FWD_RF, combinational
module fwd_sel
  import hazard_pkg::*;
(
  input  logic             en_i,
  input  logic [REG_W-1:0] rs_e_i,
  input  logic [REG_W-1:0] rd_m_i,
  input  logic [REG_W-1:0] rd_w_i,
  input  logic             reg_write_m_i,
  input  logic             reg_write_w_i,
  output logic [FWD_W-1:0] fwd_o
);

  // M is younger than W, so its value wins.
  always_comb begin
    fwd_o = FWD_RF;
    if (en_i) begin
      if (reg_hit(reg_write_m_i, rd_m_i, rs_e_i)) begin
        fwd_o = FWD_MEM;
      end else if (reg_hit(reg_write_w_i, rd_w_i, rs_e_i)) begin
        fwd_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush and multi-cycle
// execute-unit sequencing for the 5-stage core.
//   clk, rst : clock, asynchronous active-low reset
//   hz       : hazard_ctrl_if.slave (pipeline taps in, controls out)
// Parameters: MC_LATENCY (2..16) cycles a multi-cycle op occupies E,
//             CNT_W performance counter width.
// Build option: HAZARD_PERF_CNT_EN builds the StallCnt/FlushCnt counters;
// without it both read zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input logic           clk,
  input logic           rst,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned MC_CNT_W = $clog2(MC_LATENCY);

  mc_state_e           state_q, state_d;
  logic [MC_CNT_W-1:0] cnt_q, cnt_d;
  logic                mc_start, mc_stall, mc_done;
  logic                lw, lw_act, br;

  fwd_sel u_fwd_a (
    .en_i          (rst),
    .rs_e_i        (hz.Rs1E),
    .rd_m_i        (hz.RdM),
    .rd_w_i        (hz.RdW),
    .reg_write_m_i (hz.RegWriteM),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (hz.ForwardAE)
  );

  fwd_sel u_fwd_b (
    .en_i          (rst),
    .rs_e_i        (hz.Rs2E),
    .rd_m_i        (hz.RdM),
    .rd_w_i        (hz.RdW),
    .reg_write_m_i (hz.RegWriteM),
    .reg_write_w_i (hz.RegWriteW),
    .fwd_o         (hz.ForwardBE)
  );

  // Multi-cycle sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the start cycle counts as the first occupancy cycle, so BUSY
  // loads MC_LATENCY-2 and the release cycle is the one with cnt==0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_start = 1'b0;
    mc_stall = 1'b0;
    mc_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rst && hz.MultiCycleE) begin
          mc_start = 1'b1;
          mc_stall = 1'b1;
          cnt_d    = MC_CNT_W'(MC_LATENCY - 2);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          mc_stall = 1'b1;
          cnt_d    = cnt_q - MC_CNT_W'(1);
        end else begin
          mc_done = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load-use only acts in IDLE; a taken branch overrides its stall.
  assign lw     = hz.ResultSrcE && (hz.RdE != '0) &&
                  ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign lw_act = rst && (state_q == IDLE) && lw;
  assign br     = rst && hz.PCSrcE;

  assign hz.StallF   = mc_stall || (lw_act && !br);
  assign hz.StallD   = mc_stall || (lw_act && !br);
  assign hz.StallE   = mc_stall;
  assign hz.FlushD   = br;
  assign hz.FlushE   = br || lw_act;
  assign hz.FlushM   = mc_stall;
  assign hz.McStartE = mc_start;
  assign hz.McDoneE  = mc_done;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // One increment per cycle even when FlushD and FlushE are both high.
  assign stall_cnt_d = stall_cnt_q + CNT_W'(hz.StallD);
  assign flush_cnt_d = flush_cnt_q + CNT_W'(hz.FlushD || hz.FlushE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign hz.StallCnt = stall_cnt_q;
  assign hz.FlushCnt = flush_cnt_q;
`else
  assign hz.StallCnt = CNT_W'(0);
  assign hz.FlushCnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl.
// dut4 runs with MC_LATENCY=4, dut2 with MC_LATENCY=2.
// Control vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,McStartE,McDoneE}.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz4 ();
  hazard_ctrl_if #(.CNT_W(CNT_W)) hz2 ();

  hazard_ctrl #(.MC_LATENCY(4), .CNT_W(CNT_W)) dut4 (.clk(clk), .rst(rst), .hz(hz4.slave));
  hazard_ctrl #(.MC_LATENCY(2), .CNT_W(CNT_W)) dut2 (.clk(clk), .rst(rst), .hz(hz2.slave));

  logic [7:0] ctl4, ctl2;
  assign ctl4 = {hz4.StallF, hz4.StallD, hz4.StallE, hz4.FlushD, hz4.FlushE,
                 hz4.FlushM, hz4.McStartE, hz4.McDoneE};
  assign ctl2 = {hz2.StallF, hz2.StallD, hz2.StallE, hz2.FlushD, hz2.FlushE,
                 hz2.FlushM, hz2.McStartE, hz2.McDoneE};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear4;
    hz4.Rs1D = '0; hz4.Rs2D = '0; hz4.Rs1E = '0; hz4.Rs2E = '0; hz4.RdE = '0;
    hz4.ResultSrcE = 1'b0; hz4.MultiCycleE = 1'b0; hz4.PCSrcE = 1'b0;
    hz4.RdM = '0; hz4.RdW = '0; hz4.RegWriteM = 1'b0; hz4.RegWriteW = 1'b0;
  endtask

  task automatic clear2;
    hz2.Rs1D = '0; hz2.Rs2D = '0; hz2.Rs1E = '0; hz2.Rs2E = '0; hz2.RdE = '0;
    hz2.ResultSrcE = 1'b0; hz2.MultiCycleE = 1'b0; hz2.PCSrcE = 1'b0;
    hz2.RdM = '0; hz2.RdW = '0; hz2.RegWriteM = 1'b0; hz2.RegWriteW = 1'b0;
  endtask

  // Outputs must stay quiet under reset even with hazard-provoking inputs.
  task automatic test_reset;
    rst = 1'b0;
    clear4(); clear2();
    hz4.Rs1E = 5'd5; hz4.Rs2E = 5'd5; hz4.RdM = 5'd5; hz4.RegWriteM = 1'b1;
    hz4.PCSrcE = 1'b1; hz4.MultiCycleE = 1'b1;
    hz4.ResultSrcE = 1'b1; hz4.RdE = 5'd3; hz4.Rs1D = 5'd3;
    tick();
    checks++;
    if (ctl4 !== 8'b0) begin
      failures++; $display("FAIL reset_ctl got=%b want=%b", ctl4, 8'b0);
    end
    checks++;
    if ({hz4.ForwardAE, hz4.ForwardBE} !== 4'b0000) begin
      failures++; $display("FAIL reset_fwd got=%b want=0000", {hz4.ForwardAE, hz4.ForwardBE});
    end
    checks++;
    if ({hz4.StallCnt, hz4.FlushCnt} !== '0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", hz4.StallCnt, hz4.FlushCnt);
    end
    clear4();
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (ctl4 !== 8'b0) begin
      failures++; $display("FAIL post_reset_idle got=%b want=%b", ctl4, 8'b0);
    end
  endtask

  task automatic test_forward;
    clear4();
    hz4.RdM = 5'd5; hz4.RdW = 5'd5; hz4.Rs1E = 5'd5; hz4.Rs2E = 5'd3;
    hz4.RegWriteM = 1'b1; hz4.RegWriteW = 1'b1;
    #1;
    checks++;
    if ({hz4.ForwardAE, hz4.ForwardBE} !== 4'b1000) begin
      failures++; $display("FAIL fwd_m_prio got=%b want=1000", {hz4.ForwardAE, hz4.ForwardBE});
    end
    hz4.RegWriteM = 1'b0;
    #1;
    checks++;
    if (hz4.ForwardAE !== FWD_WB) begin
      failures++; $display("FAIL fwd_w got=%b want=01", hz4.ForwardAE);
    end
    hz4.RdM = 5'd0; hz4.RdW = 5'd0; hz4.Rs1E = 5'd0; hz4.RegWriteM = 1'b1;
    #1;
    checks++;
    if (hz4.ForwardAE !== FWD_RF) begin
      failures++; $display("FAIL fwd_x0 got=%b want=00", hz4.ForwardAE);
    end
    hz4.Rs1E = 5'd4; hz4.Rs2E = 5'd9; hz4.RdM = 5'd9; hz4.RdW = 5'd9;
    hz4.RegWriteM = 1'b1; hz4.RegWriteW = 1'b1;
    #1;
    checks++;
    if ({hz4.ForwardAE, hz4.ForwardBE} !== 4'b0010) begin
      failures++; $display("FAIL fwd_b_m got=%b want=0010", {hz4.ForwardAE, hz4.ForwardBE});
    end
    hz4.RdM = 5'd2;
    #1;
    checks++;
    if (hz4.ForwardBE !== FWD_WB) begin
      failures++; $display("FAIL fwd_b_w got=%b want=01", hz4.ForwardBE);
    end
    hz4.RegWriteW = 1'b0;
    #1;
    checks++;
    if (hz4.ForwardBE !== FWD_RF) begin
      failures++; $display("FAIL fwd_b_none got=%b want=00", hz4.ForwardBE);
    end
    clear4();
    tick();
  endtask

  task automatic test_load_use;
    clear4();
    hz4.ResultSrcE = 1'b1; hz4.RdE = 5'd7; hz4.Rs2D = 5'd7; hz4.Rs1D = 5'd1;
    #1;
    checks++;
    if (ctl4 !== 8'b11001000) begin
      failures++; $display("FAIL load_use got=%b want=%b", ctl4, 8'b11001000);
    end
    tick();
    // Bubble now in E: the stall lasts exactly one cycle.
    clear4(); hz4.Rs2D = 5'd7;
    #1;
    checks++;
    if (ctl4 !== 8'b0) begin
      failures++; $display("FAIL load_use_release got=%b want=%b", ctl4, 8'b0);
    end
    hz4.ResultSrcE = 1'b1; hz4.RdE = 5'd0; hz4.Rs1D = 5'd0;
    #1;
    checks++;
    if (ctl4 !== 8'b0) begin
      failures++; $display("FAIL load_use_x0 got=%b want=%b", ctl4, 8'b0);
    end
    clear4();
    tick();
  endtask

  task automatic test_branch;
    clear4();
    hz4.ResultSrcE = 1'b1; hz4.RdE = 5'd6; hz4.Rs1D = 5'd6; hz4.PCSrcE = 1'b1;
    #1;
    checks++;
    if (ctl4 !== 8'b00011000) begin
      failures++; $display("FAIL branch_over_lw got=%b want=%b", ctl4, 8'b00011000);
    end
    tick();
    clear4(); hz4.PCSrcE = 1'b1;
    #1;
    checks++;
    if (ctl4 !== 8'b00011000) begin
      failures++; $display("FAIL branch_only got=%b want=%b", ctl4, 8'b00011000);
    end
    clear4();
    tick();
  endtask

  // Op held in E for its whole occupancy; a load hazard during BUSY is masked,
  // and MultiCycleE in the release cycle must not restart the unit.
  task automatic test_multicycle;
    logic [7:0] exp;
    clear4();
    for (int c = 0; c < 5; c++) begin
      hz4.MultiCycleE = (c < 4);
      if (c == 1 || c == 2) begin
        hz4.ResultSrcE = 1'b1; hz4.RdE = 5'd7; hz4.Rs1D = 5'd7;
      end else begin
        hz4.ResultSrcE = 1'b0; hz4.RdE = 5'd0; hz4.Rs1D = 5'd0;
      end
      case (c)
        0:       exp = 8'b11100110;
        1, 2:    exp = 8'b11100100;
        3:       exp = 8'b00000001;
        default: exp = 8'b00000000;
      endcase
      #1;
      checks++;
      if (ctl4 !== exp) begin
        failures++; $display("FAIL mc4_cycle%0d got=%b want=%b", c, ctl4, exp);
      end
      tick();
    end
    clear4();
  endtask

  task automatic test_mc_lat2;
    logic [7:0] exp;
    clear2();
    for (int c = 0; c < 3; c++) begin
      hz2.MultiCycleE = (c < 2);
      case (c)
        0:       exp = 8'b11100110;
        1:       exp = 8'b00000001;
        default: exp = 8'b00000000;
      endcase
      #1;
      checks++;
      if (ctl2 !== exp) begin
        failures++; $display("FAIL mc2_cycle%0d got=%b want=%b", c, ctl2, exp);
      end
      tick();
    end
    clear2();
  endtask

  task automatic test_reset_mid_op;
    clear4();
    hz4.MultiCycleE = 1'b1;
    tick();
    // BUSY cycle 1; reset arrives between edges.
    hz4.Rs1E = 5'd8; hz4.RdM = 5'd8; hz4.RegWriteM = 1'b1;
    #1;
    checks++;
    if (ctl4 !== 8'b11100100) begin
      failures++; $display("FAIL mid_busy got=%b want=%b", ctl4, 8'b11100100);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({ctl4, hz4.ForwardAE, hz4.ForwardBE} !== 12'b0) begin
      failures++; $display("FAIL mid_reset_async got=%b want=%b",
                           {ctl4, hz4.ForwardAE, hz4.ForwardBE}, 12'b0);
    end
    clear4();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (hz4.McDoneE !== 1'b0 || ctl4 !== 8'b0) begin
        failures++; $display("FAIL mid_reset_hold%0d got=%b want=%b", c, ctl4, 8'b0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if (ctl4 !== 8'b0) begin
      failures++; $display("FAIL after_abort_idle got=%b want=%b", ctl4, 8'b0);
    end
    test_multicycle();
  endtask

  // 3 load-use stalls + one 4-cycle op (3 stall cycles) + 2 branches.
  task automatic test_counters;
    logic [CNT_W-1:0] exp_s, exp_f;
    @(negedge clk);
    rst = 1'b0;
    clear4();
    #2;
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      hz4.ResultSrcE = 1'b1; hz4.RdE = 5'(i + 1); hz4.Rs1D = 5'(i + 1);
      tick();
      clear4();
      tick();
    end
    test_multicycle();
    for (int i = 0; i < 2; i++) begin
      hz4.PCSrcE = 1'b1;
      tick();
      clear4();
      tick();
    end
`ifdef HAZARD_PERF_CNT_EN
    exp_s = CNT_W'(6);
    exp_f = CNT_W'(5);
`else
    exp_s = CNT_W'(0);
    exp_f = CNT_W'(0);
`endif
    checks++;
    if (hz4.StallCnt !== exp_s) begin
      failures++; $display("FAIL stall_cnt got=%0d want=%0d", hz4.StallCnt, exp_s);
    end
    checks++;
    if (hz4.FlushCnt !== exp_f) begin
      failures++; $display("FAIL flush_cnt got=%0d want=%0d", hz4.FlushCnt, exp_f);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_multicycle();
    test_mc_lat2();
    test_reset_mid_op();
    test_counters();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It generates the execute-stage operand forwarding selects (ForwardAE/ForwardBE), load-use stalls, and taken-branch flushes. It also sequences a shared multi-cycle execute unit by holding F/D/E and bubbling M while that unit iterates. It sits beside the pipeline, reading register indices and control bits from D/E/M/W and driving stall, flush and start signals back into the stage registers.

## Interface
- MC_LATENCY, 4: total cycles a multi-cycle op occupies E; legal range 2..16.
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- Rs1D, Rs2D  in  5  source registers of the instruction in D
- Rs1E, Rs2E, RdE  in  5  source and destination registers of the instruction in E
- ResultSrcE  in  1  instruction in E is a load
- MultiCycleE  in  1  instruction in E uses the multi-cycle unit
- PCSrcE  in  1  taken branch/jump resolved in E
- RdM, RdW  in  5  destinations in M and W
- RegWriteM, RegWriteW  in  1  M and W write the register file
- ForwardAE, ForwardBE  out  2  operand select: 00 RD1E/RD2E, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE  out  1  hold the PC, IF/ID and ID/EX registers
- FlushD, FlushE, FlushM  out  1  load a bubble into IF/ID, ID/EX and EX/MEM
- McStartE  out  1  one-cycle pulse; the multi-cycle unit latches its operands
- McDoneE  out  1  last occupancy cycle; the unit's result is valid
- StallCnt, FlushCnt  out  CNT_W  performance counters

## Operation
- Forwarding (combinational), shown for operand A; operand B is identical using Rs2E:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E;
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E;
  - else 00.
  - M has priority over W.
- Load-use detection: lw = ResultSrcE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). When the FSM is IDLE, lw asserts StallF, StallD and FlushE.
- Branch: PCSrcE asserts FlushD and FlushE.
  - If lw and PCSrcE are both high, the flush wins and StallF/StallD stay low.
- Multi-cycle FSM, states IDLE and BUSY, with down-counter cnt of width clog2(MC_LATENCY).
  - IDLE && MultiCycleE:
    - McStartE=1;
    - StallF/D/E=1, FlushM=1;
    - cnt <= MC_LATENCY-2;
    - next state BUSY.
  - BUSY && cnt!=0: StallF/D/E=1, FlushM=1, cnt decrements.
  - BUSY && cnt==0: McDoneE=1, all stalls released, next state IDLE.
  - When MC_LATENCY==2, the FSM enters BUSY with cnt=0 and finishes the next cycle.
- While in BUSY, lw and the FlushE it would cause are masked. PCSrcE cannot be high in BUSY because a multi-cycle op is not a branch.
- The FSM never enters BUSY from its own release cycle. A new MultiCycleE instruction is only sampled in IDLE.
- Operand forwarding is valid only in the McStartE cycle. The unit is responsible for capturing its operands then.

## Timing
- Forward, stall and flush outputs are combinational from inputs and state, valid in the same cycle.
- A multi-cycle op stalls for MC_LATENCY-1 cycles and occupies E for MC_LATENCY cycles.
- While rst=0:
  - state=IDLE, cnt=0, counters=0;
  - all 1-bit outputs are 0, ForwardAE=ForwardBE=00.
- Asserting reset mid-BUSY aborts to IDLE immediately. No McDoneE is issued.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - StallCnt increments on every cycle with StallD=1.
  - FlushCnt increments on every cycle with FlushE=1 or FlushD=1 (by 1, not 2).
  - Both counters wrap modulo 2^CNT_W and are cleared by reset.
- Without HAZARD_PERF_CNT_EN: no counter registers are built and StallCnt=FlushCnt=0.

## Structure
- Shared package hazard_pkg holds:
  - forward encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the FSM state type (IDLE, BUSY).
- Sub-module fwd_sel contains the per-operand comparator and priority logic. hazard_ctrl instantiates it twice, for A and B.

## Test plan
- Forward priority: RdM=RdW=Rs1E=5 with RegWriteM=RegWriteW=1 -> ForwardAE=10. Then RegWriteM=0 -> 01. Then RdM=RdW=0 -> 00.
- Load-use: ResultSrcE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for exactly one cycle, FlushD=0.
- Branch: PCSrcE=1 together with lw -> FlushD=FlushE=1, StallF=StallD=0.
- Multi-cycle with MC_LATENCY=4: MultiCycleE pulse -> McStartE on cycle 0; stalls and FlushM high on cycles 0-2; McDoneE with stalls low on cycle 3; then IDLE. Repeat the test with MC_LATENCY=2 to get one stall cycle.
- Reset mid-op: rst=0 on BUSY cycle 1 -> all outputs 0 asynchronously, no McDoneE. After release, a new MultiCycleE gives a full MC_LATENCY sequence.
- Counters, with HAZARD_PERF_CNT_EN: 3 load-use stalls plus one 4-cycle op -> StallCnt=6. Branch flushes give FlushCnt equal to the branch count plus the load-use count. Without the macro, both counters read 0.
